// File: rtl/dsky_pkg.sv
// Shared constants and types for the DSKY relay-word decoder and its event queue.
package dsky_pkg;

   localparam int NUM_ROWS = 12;
   localparam int ROW_W    = 4;
   localparam int DATA_W   = 11;
   localparam int WORD_W   = ROW_W + DATA_W;

   typedef struct packed {
      logic [ROW_W-1:0]  row;
      logic [DATA_W-1:0] data;
   } evt_rec_t;

   typedef enum logic {
      ST_DISARMED = 1'b0,
      ST_ARMED    = 1'b1
   } latch_state_e;

   // Only relay words 1..NUM_ROWS map onto the row table.
   function automatic logic row_is_valid(input logic [ROW_W-1:0] row);
      return (row != '0) && (row <= ROW_W'(NUM_ROWS));
   endfunction

endpackage

// File: rtl/dsky_evt_fifo.sv
// Synchronous change-event queue; a push into a full queue is accepted only alongside a pop.
module dsky_evt_fifo
   import dsky_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [WORD_W-1:0] push_data,
   input  logic              pop,
   output logic [WORD_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              do_push, do_pop;

   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/dsky_relay_decoder.sv
// Relay-word decoder: synchronises RYWD/RLYB, debounces, latches rows 1..12 into a table.
// Optional change-event queue enabled by defining DSKY_EVENT_FIFO_EN.
module dsky_relay_decoder
   import dsky_pkg::*;
#(
   parameter int SETTLE_CYCLES = 64,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  rywd,
   input  logic [10:0] rlyb,
   input  logic [3:0]  rd_addr,
   output logic [10:0] rd_data,
   output logic        evt_valid,
   input  logic        evt_ready,
   output logic [3:0]  evt_row,
   output logic [10:0] evt_data,
   output logic        evt_overflow,
   input  logic        clr_overflow
);

   localparam int               CNT_W    = $clog2(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   logic [WORD_W-1:0] sync1_q, sync1_d;
   logic [WORD_W-1:0] sync2_q, sync2_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   latch_state_e      state_q, state_d;
   logic [DATA_W-1:0] table_q [NUM_ROWS];
   logic [DATA_W-1:0] table_d [NUM_ROWS];
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   logic              word_clear;
   logic              do_latch;
   logic              do_write;
   logic              data_changed;
   logic [ROW_W-1:0]  cur_row;
   logic [DATA_W-1:0] cur_data;
   logic [ROW_W-1:0]  wr_idx;
   logic [ROW_W-1:0]  rd_idx;

   // The clear looks at the word about to enter sync2, so the count starts on the
   // same edge the new word is sampled and the pin-to-write latency is 2+SETTLE_CYCLES.
   always_comb begin
      sync1_d    = {rywd, rlyb};
      sync2_d    = sync1_q;
      word_clear = (sync1_q != sync2_q) || (sync1_q[WORD_W-1 -: ROW_W] == '0);
      cur_row    = sync2_q[WORD_W-1 -: ROW_W];
      cur_data   = sync2_q[DATA_W-1:0];
      do_latch   = (state_q == ST_ARMED) && (cnt_q == CNT_LAST);

      cnt_d = cnt_q;
      if (word_clear) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_LAST) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      state_d = state_q;
      if (word_clear) begin
         state_d = ST_ARMED;
      end else if (do_latch) begin
         state_d = ST_DISARMED;
      end

      wr_idx       = cur_row - ROW_W'(1);
      do_write     = do_latch && row_is_valid(cur_row);
      data_changed = (table_q[wr_idx] != cur_data);

      table_d = table_q;
      if (do_write) begin
         table_d[wr_idx] = cur_data;
      end

      rd_idx    = rd_addr - ROW_W'(1);
      rd_data_d = row_is_valid(rd_addr) ? table_q[rd_idx] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         cnt_q     <= '0;
         state_q   <= ST_ARMED;
         rd_data_q <= '0;
         for (int i = 0; i < NUM_ROWS; i++) begin
            table_q[i] <= '0;
         end
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         rd_data_q <= rd_data_d;
         table_q   <= table_d;
      end
   end

   assign rd_data = rd_data_q;

`ifdef DSKY_EVENT_FIFO_EN
   logic              evt_push;
   logic              evt_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              overflow_q, overflow_d;
   logic [WORD_W-1:0] fifo_head;
   evt_rec_t          push_rec;
   evt_rec_t          head_rec;

   // A fresh overflow wins over a clear arriving in the same cycle.
   always_comb begin
      evt_push      = do_write && data_changed;
      evt_pop       = evt_ready && !fifo_empty;
      push_rec.row  = cur_row;
      push_rec.data = cur_data;
      overflow_d    = overflow_q;
      if (evt_push && fifo_full && !evt_pop) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   dsky_evt_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (evt_push),
      .push_data (push_rec),
      .pop       (evt_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head_rec     = fifo_head;
   assign evt_valid    = !fifo_empty;
   assign evt_row      = head_rec.row;
   assign evt_data     = head_rec.data;
   assign evt_overflow = overflow_q;
`else
   logic unused_evt;
   assign unused_evt   = ^{evt_ready, clr_overflow, data_changed};
   assign evt_valid    = 1'b0;
   assign evt_row      = '0;
   assign evt_data     = '0;
   assign evt_overflow = 1'b0;
`endif

endmodule
